// File: rtl/muxpga_grid.sv
// muxpga_grid: ROWS x COLS mux-routed ALU cell grid with a serial nibble config chain and a burst controller
//   clk, reset     clock; synchronous active-high reset
//   cmd            00 HOLD, 01 SHIFT, 10 RUN, 11 BURST start
//   cfg_in         config nibble shifted into chain word 0 on SHIFT while idle
//   in_data        north input of row 0
//   burst_len      burst length, sampled on BURST start
//   out_data       q of the bottom row, column 0 in the LSBs
//   busy, done     burst in progress; one-cycle completion pulse
//   cfg_out        last chain word when MUXPGA_CFG_READBACK_EN is defined, else 4'h0
module muxpga_grid #(
   parameter int ROWS  = 4,
   parameter int COLS  = 3,
   parameter int W     = 4,
   parameter int CNT_W = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [1:0]          cmd,
   input  logic [3:0]          cfg_in,
   input  logic [W-1:0]        in_data,
   input  logic [CNT_W-1:0]    burst_len,
   output logic [COLS*W-1:0]   out_data,
   output logic                busy,
   output logic                done,
   output logic [3:0]          cfg_out
);
   localparam int N = ROWS * COLS;
   typedef enum logic {IDLE, BURST} state_t;
   state_t st, st_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic done_d, en, shift;
   logic [8*N-1:0] chain;
   logic [N*W-1:0] dff, q;

   function automatic logic [W-1:0] pick(input logic [1:0] s, input logic [W-1:0] n, so, we, ea);
      return s == 2'd0 ? n : s == 2'd1 ? so : s == 2'd2 ? we : ea;
   endfunction

   function automatic logic [W-1:0] alu(input logic [2:0] op, input logic [W-1:0] a, b);
      case (op)
         3'd0:    return a | b;
         3'd1:    return a & b;
         3'd2:    return a + 1'b1;
         3'd3:    return b;
         3'd4:    return a ^ b;
         3'd5:    return a + b;
         3'd6:    return a - b;
         default: return a << 1;
      endcase
   endfunction

   // Comb-bypass cells are resolved by N+1 unrolled relaxation stages instead of a
   // structural feedback loop: stage 0 starts from the dffs and every stage re-evaluates
   // all cells from the previous one. An acyclic comb chain is at most N cells deep, so
   // the last stage holds the settled q, and its ALU outputs are the dff next values.
   genvar i, k;
   for (i = 0; i <= N; i++) begin : g_it
      logic [N*W-1:0] p, nx, f;
      if (i == 0) begin : g_base
         assign p = dff;
      end else begin : g_link
         assign p = g_it[i-1].nx;
      end
      for (k = 0; k < N; k++) begin : g_cell
         localparam int R  = k / COLS;
         localparam int C  = k % COLS;
         localparam int NO = R == 0 ? k : k - COLS;
         localparam int SO = ((R + 1) % ROWS) * COLS + C;
         localparam int WE = R * COLS + (C + COLS - 1) % COLS;
         localparam int EA = R * COLS + (C + 1) % COLS;
         logic [W-1:0] north, in1, in2;
         logic [3:0] mux, func;
         assign mux   = chain[8*k +: 4];
         assign func  = chain[8*k+4 +: 4];
         assign north = R == 0 ? in_data : p[NO*W +: W];
         assign in1   = pick(mux[1:0], north, p[SO*W +: W], p[WE*W +: W], p[EA*W +: W]);
         assign in2   = pick(mux[3:2], north, p[SO*W +: W], p[WE*W +: W], p[EA*W +: W]);
         assign f[k*W +: W]  = alu(func[2:0], in1, in2);
         assign nx[k*W +: W] = en && func[3] ? f[k*W +: W] : dff[k*W +: W];
      end
   end

   assign q        = g_it[N].nx;
   assign out_data = q[(ROWS-1)*COLS*W +: COLS*W];
   assign busy     = st == BURST;

   always_comb begin
      st_d   = st;
      cnt_d  = cnt;
      done_d = 1'b0;
      en     = st == BURST || cmd == 2'b10;
      shift  = st == IDLE && cmd == 2'b01;
      if (st == BURST) begin
         cnt_d  = cnt - 1'b1;
         st_d   = cnt == CNT_W'(1) ? IDLE : BURST;
         done_d = cnt == CNT_W'(1);
      end else if (cmd == 2'b11) begin
         cnt_d  = burst_len;
         st_d   = burst_len != '0 ? BURST : IDLE;
         done_d = burst_len == '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st    <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         chain <= '0;
         dff   <= '0;
      end else begin
         st   <= st_d;
         cnt  <= cnt_d;
         done <= done_d;
         if (shift) chain <= {chain[8*N-5:0], cfg_in};
         if (en) dff <= g_it[N].f;
      end
   end

`ifdef MUXPGA_CFG_READBACK_EN
   assign cfg_out = chain[8*N-1 -: 4];
`else
   assign cfg_out = 4'h0;
`endif
endmodule
